mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory stage pair MEM_B and WB, downstream of execute.
//  - Takes execute's registered MEM_A-boundary outputs.
//  - Issues the data-memory request in the MEM_A cycle, lane-aligning store data and byte enables.
//  - Captures the memory read data one cycle later and zero-extends the loaded lane.
//  - Registers results into the MEM_B and WB boundaries, whose tgt/result/bubble/is_load outputs feed execute forwarding and the regfile write port.
// PARAMETERS
//  none (all widths fixed by the ISA: 32-bit data, 5-bit regs, 5-bit opcodes)
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst            in   1   synchronous, active-high reset
//  halt           in   1   global freeze: all registers hold
//  ex_bubble      in   1   MEM_A slot is empty
//  ex_opcode      in   5   MEM_A opcode
//  ex_tgt_1/2     in   5   MEM_A dest regs (0 = none)
//  ex_result_1/2  in   32  MEM_A results (result_2 = post-inc base)
//  ex_addr        in   32  byte address of the access
//  ex_store_data  in   32  unshifted store data
//  ex_we          in   4   unshifted enables: F / 3 / 1 for word / double / byte
//  ex_is_load     in   1   MEM_A slot is a load
//  ex_halt        in   1   halt instruction in MEM_A
//  mem_addr       out  32  word address {ex_addr[31:2],2'b00}
//  mem_wdata      out  32  lane-shifted store data
//  mem_we         out  4   lane-shifted byte enables
//  mem_rdata      in   32  read data, valid the cycle after mem_addr
//  mem_b_tgt_1/2, mem_b_result_out_1/2, mem_b_bubble, mem_b_is_load   out  MEM_B boundary
//  wb_tgt_1/2, wb_result_out_1/2, wb_bubble   out  WB boundary
//  halt_in_wb     out  1   halt instruction has reached WB
// BEHAVIOUR
//  - Reset (rst=1, dominates halt): both boundaries are bubbles.
//    - Outputs: tgt 0, results 0, bubble 1, is_load 0, halt_in_wb 0.
//    - Internal shift/class registers: 0.
//    - mem_we is forced to 0 during rst.
//  - Request path (combinational from ex_*):
//    - sh = ex_addr[1:0].
//    - mem_we = ex_bubble ? 0 : ex_we << sh.
//    - mem_wdata = ex_store_data << (8*sh).
//    - The word-class shift uses sh=0.
//  - MEM_B register (on ~halt):
//    - Captures ex_* fields, sh and the access class (word 3-5, double 6-8, byte 9-11).
//    - A bubble forces tgt 0 and is_load 0.
//  - Load data alignment (combinational from MEM_B state): data = mem_rdata >> (8*sh_b).
//    - Word: no mask. Double: data[15:0]. Byte: data[7:0].
//    - Double and byte loads are zero-extended.
//  - WB register (on ~halt):
//    - Copies the MEM_B slot.
//    - wb_result_out_1 = mem_b_is_load ? aligned data : mem_b_result_out_1.
//    - wb_result_out_2 = mem_b_result_out_2 (post-inc base is never replaced).
//  - Latency: ex_* -> MEM_B is 1 cycle; -> WB is 2 cycles. Throughput is 1 per cycle, with no internal stall.
//  - The MEM_B load result is not forwardable.
//    - mem_b_result_out_1 carries the address until WB.
//    - Execute stalls on mem_b_is_load.
//  - halt=1: MEM_B and WB hold; mem_we = 0 so no duplicate store. mem_rdata is ignored.
//    - Memory must hold mem_rdata stable while halt is asserted, or the team's memory wrapper re-reads mem_addr on release.
//  - halt_in_wb <= MEM_B halt & ~mem_b_bubble. Once set, it is sticky until rst.
//  - A bubble entering a boundary carries its tgt (0) forward, so forwarding never hits a bubble.
//  - Reset mid-operation: any in-flight MEM_B load is discarded. WB shows a bubble the next cycle.
// CONFIGURATION
//  - MEM_STAGE_MISALIGN_CHECK_EN defined: an access is misaligned when it is word with sh!=0, or double with sh[0]=1.
//    - A misaligned access forces mem_we=0.
//    - A misaligned load turns into a WB bubble (tgt 0).
//    - A new output misalign_fault (1 bit) goes high with the WB slot of the offending instruction. It is sticky until rst.
//  - Not defined:
//    - No check; the port is absent.
//    - Misaligned accesses shift blindly; bytes past bit 31 are dropped.
// STRUCTURE
//  - Shared package (dioptase_pkg): opcode constants for the word/double/byte load-store ranges, and an access-class enum {ACC_W, ACC_D, ACC_B, ACC_NONE}.
//  - Sub-module load_align: (rdata, sh, class) -> zero-extended 32-bit data; purely combinational.
// TESTING
//  1. Word store, then load:
//     - Store: opcode 3, addr 0x100, data 0xDEADBEEF, we F -> mem_we F, mem_addr 0x100.
//     - Load from 0x100 -> wb_result_out_1 = 0xDEADBEEF two cycles later.
//  2. Byte store: opcode 9, addr 0x103, data 0x000000AB, we 1 -> mem_we 8, mem_wdata 0xAB000000.
//     - Byte load from 0x103 with mem_rdata 0xAB112233 -> WB result 0x000000AB.
//  3. Double load: opcode 6, addr 0x102, mem_rdata 0x8001FFFF -> WB result 0x00008001 (zero-extend).
//  4. Post-inc load:
//     - ex_result_2 = 0x104, tgt_2 = r5, tgt_1 = r6, rdata 0x55.
//     - WB shows r6 = 0x55 and r5 = 0x104 in the same slot.
//  5. Halt:
//     - halt held 3 cycles with a store in MEM_A -> mem_we 0 throughout; boundaries unchanged.
//     - On release, the store is issued exactly once.
//  6. Reset: rst with a load in MEM_B -> next cycle wb_bubble=1, wb_tgt 0, halt_in_wb 0.
//  7. With MEM_STAGE_MISALIGN_CHECK_EN: word store at 0x102 -> mem_we 0, misalign_fault=1 two cycles later.

Source files
------------

// File: rtl/dioptase_pkg.sv
// Shared Dioptase definitions: load/store opcode ranges and the access-class enum
// used by the memory stage and its load aligner.
package dioptase_pkg;

   localparam logic [4:0] OP_LDST_W_LO = 5'd3;
   localparam logic [4:0] OP_LDST_W_HI = 5'd5;
   localparam logic [4:0] OP_LDST_D_LO = 5'd6;
   localparam logic [4:0] OP_LDST_D_HI = 5'd8;
   localparam logic [4:0] OP_LDST_B_LO = 5'd9;
   localparam logic [4:0] OP_LDST_B_HI = 5'd11;

   typedef enum logic [1:0] {
      ACC_W    = 2'd0,
      ACC_D    = 2'd1,
      ACC_B    = 2'd2,
      ACC_NONE = 2'd3
   } acc_class_e;

   function automatic acc_class_e acc_class(input logic [4:0] op);
      if (op >= OP_LDST_W_LO && op <= OP_LDST_W_HI) return ACC_W;
      if (op >= OP_LDST_D_LO && op <= OP_LDST_D_HI) return ACC_D;
      if (op >= OP_LDST_B_LO && op <= OP_LDST_B_HI) return ACC_B;
      return ACC_NONE;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane alignment: shifts the addressed lane down and zero-extends
// double and byte loads. Purely combinational.
module load_align
   import dioptase_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  sh,
   input  acc_class_e  acc,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {sh, 3'b000};
      case (acc)
         ACC_D:   data = {16'h0000, shifted[15:0]};
         ACC_B:   data = {24'h000000, shifted[7:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage pair MEM_B / WB: issues the data-memory request from MEM_A,
// aligns load data and registers the MEM_B and WB boundaries.
// Optional misaligned-access checking is enabled by MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage
   import dioptase_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        ex_bubble,
   input  logic [4:0]  ex_opcode,
   input  logic [4:0]  ex_tgt_1,
   input  logic [4:0]  ex_tgt_2,
   input  logic [31:0] ex_result_1,
   input  logic [31:0] ex_result_2,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic [3:0]  ex_we,
   input  logic        ex_is_load,
   input  logic        ex_halt,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_rdata,
   output logic [4:0]  mem_b_tgt_1,
   output logic [4:0]  mem_b_tgt_2,
   output logic [31:0] mem_b_result_out_1,
   output logic [31:0] mem_b_result_out_2,
   output logic        mem_b_bubble,
   output logic        mem_b_is_load,
   output logic [4:0]  wb_tgt_1,
   output logic [4:0]  wb_tgt_2,
   output logic [31:0] wb_result_out_1,
   output logic [31:0] wb_result_out_2,
   output logic        wb_bubble,
   output logic        halt_in_wb
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   ,
   output logic        misalign_fault
`endif
);

   acc_class_e  ex_acc;
   logic [1:0]  ex_sh;
   logic [31:0] load_data;

   logic [4:0]  mem_b_tgt_1_q, mem_b_tgt_1_d, mem_b_tgt_2_q, mem_b_tgt_2_d;
   logic [31:0] mem_b_res_1_q, mem_b_res_1_d, mem_b_res_2_q, mem_b_res_2_d;
   logic        mem_b_bubble_q, mem_b_bubble_d, mem_b_is_load_q, mem_b_is_load_d;
   logic        mem_b_halt_q, mem_b_halt_d;
   logic [1:0]  mem_b_sh_q, mem_b_sh_d;
   acc_class_e  mem_b_acc_q, mem_b_acc_d;

   logic [4:0]  wb_tgt_1_q, wb_tgt_1_d, wb_tgt_2_q, wb_tgt_2_d;
   logic [31:0] wb_res_1_q, wb_res_1_d, wb_res_2_q, wb_res_2_d;
   logic        wb_bubble_q, wb_bubble_d, halt_in_wb_q, halt_in_wb_d;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   logic        ex_misalign;
   logic        mem_b_misalign_q, mem_b_misalign_d;
   logic        misalign_fault_q, misalign_fault_d;
`endif

   // Word accesses always use lane 0: the word address already selects the word.
   always_comb begin
      ex_acc    = acc_class(ex_opcode);
      ex_sh     = (ex_acc == ACC_W) ? 2'b00 : ex_addr[1:0];
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      ex_misalign = ~ex_bubble &
                    (((ex_acc == ACC_W) && (ex_addr[1:0] != 2'b00)) ||
                     ((ex_acc == ACC_D) && ex_addr[0]));
`endif
      mem_addr  = {ex_addr[31:2], 2'b00};
      mem_wdata = ex_store_data << {ex_sh, 3'b000};
      mem_we    = 4'h0;
      if (!rst && !halt && !ex_bubble) mem_we = ex_we << ex_sh;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      if (ex_misalign) mem_we = 4'h0;
`endif
   end

   load_align u_load_align (
      .rdata (mem_rdata),
      .sh    (mem_b_sh_q),
      .acc   (mem_b_acc_q),
      .data  (load_data)
   );

   always_comb begin
      mem_b_tgt_1_d   = mem_b_tgt_1_q;
      mem_b_tgt_2_d   = mem_b_tgt_2_q;
      mem_b_res_1_d   = mem_b_res_1_q;
      mem_b_res_2_d   = mem_b_res_2_q;
      mem_b_bubble_d  = mem_b_bubble_q;
      mem_b_is_load_d = mem_b_is_load_q;
      mem_b_halt_d    = mem_b_halt_q;
      mem_b_sh_d      = mem_b_sh_q;
      mem_b_acc_d     = mem_b_acc_q;
      if (!halt) begin
         mem_b_tgt_1_d   = ex_bubble ? 5'd0 : ex_tgt_1;
         mem_b_tgt_2_d   = ex_bubble ? 5'd0 : ex_tgt_2;
         mem_b_res_1_d   = ex_result_1;
         mem_b_res_2_d   = ex_result_2;
         mem_b_bubble_d  = ex_bubble;
         mem_b_is_load_d = ex_is_load & ~ex_bubble;
         mem_b_halt_d    = ex_halt & ~ex_bubble;
         mem_b_sh_d      = ex_sh;
         mem_b_acc_d     = ex_acc;
      end
   end

   always_comb begin
      wb_tgt_1_d   = wb_tgt_1_q;
      wb_tgt_2_d   = wb_tgt_2_q;
      wb_res_1_d   = wb_res_1_q;
      wb_res_2_d   = wb_res_2_q;
      wb_bubble_d  = wb_bubble_q;
      halt_in_wb_d = halt_in_wb_q;
      if (!halt) begin
         wb_tgt_1_d   = mem_b_tgt_1_q;
         wb_tgt_2_d   = mem_b_tgt_2_q;
         wb_res_1_d   = mem_b_is_load_q ? load_data : mem_b_res_1_q;
         wb_res_2_d   = mem_b_res_2_q;
         wb_bubble_d  = mem_b_bubble_q;
         halt_in_wb_d = halt_in_wb_q | (mem_b_halt_q & ~mem_b_bubble_q);
      end
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      mem_b_misalign_d = halt ? mem_b_misalign_q : ex_misalign;
      misalign_fault_d = misalign_fault_q;
      if (!halt && mem_b_misalign_q && !mem_b_bubble_q) begin
         misalign_fault_d = 1'b1;
         // A misaligned load never writes the regfile.
         if (mem_b_is_load_q) begin
            wb_tgt_1_d  = 5'd0;
            wb_tgt_2_d  = 5'd0;
            wb_bubble_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_b_tgt_1_q   <= 5'd0;
         mem_b_tgt_2_q   <= 5'd0;
         mem_b_res_1_q   <= 32'h0;
         mem_b_res_2_q   <= 32'h0;
         mem_b_bubble_q  <= 1'b1;
         mem_b_is_load_q <= 1'b0;
         mem_b_halt_q    <= 1'b0;
         mem_b_sh_q      <= 2'b00;
         mem_b_acc_q     <= ACC_W;
         wb_tgt_1_q      <= 5'd0;
         wb_tgt_2_q      <= 5'd0;
         wb_res_1_q      <= 32'h0;
         wb_res_2_q      <= 32'h0;
         wb_bubble_q     <= 1'b1;
         halt_in_wb_q    <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
         mem_b_misalign_q <= 1'b0;
         misalign_fault_q <= 1'b0;
`endif
      end else begin
         mem_b_tgt_1_q   <= mem_b_tgt_1_d;
         mem_b_tgt_2_q   <= mem_b_tgt_2_d;
         mem_b_res_1_q   <= mem_b_res_1_d;
         mem_b_res_2_q   <= mem_b_res_2_d;
         mem_b_bubble_q  <= mem_b_bubble_d;
         mem_b_is_load_q <= mem_b_is_load_d;
         mem_b_halt_q    <= mem_b_halt_d;
         mem_b_sh_q      <= mem_b_sh_d;
         mem_b_acc_q     <= mem_b_acc_d;
         wb_tgt_1_q      <= wb_tgt_1_d;
         wb_tgt_2_q      <= wb_tgt_2_d;
         wb_res_1_q      <= wb_res_1_d;
         wb_res_2_q      <= wb_res_2_d;
         wb_bubble_q     <= wb_bubble_d;
         halt_in_wb_q    <= halt_in_wb_d;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
         mem_b_misalign_q <= mem_b_misalign_d;
         misalign_fault_q <= misalign_fault_d;
`endif
      end
   end

   assign mem_b_tgt_1        = mem_b_tgt_1_q;
   assign mem_b_tgt_2        = mem_b_tgt_2_q;
   assign mem_b_result_out_1 = mem_b_res_1_q;
   assign mem_b_result_out_2 = mem_b_res_2_q;
   assign mem_b_bubble       = mem_b_bubble_q;
   assign mem_b_is_load      = mem_b_is_load_q;
   assign wb_tgt_1           = wb_tgt_1_q;
   assign wb_tgt_2           = wb_tgt_2_q;
   assign wb_result_out_1    = wb_res_1_q;
   assign wb_result_out_2    = wb_res_2_q;
   assign wb_bubble          = wb_bubble_q;
   assign halt_in_wb         = halt_in_wb_q;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   assign misalign_fault     = misalign_fault_q;
`endif

endmodule
